// File: rtl/ascon_perm_engine.sv
// ASCON p^a/p^b permutation engine: UNROLL rounds per clock, 0..12 rounds per request.
// Build option ASCON_PERM_MASK_OUT_EN zeroes state_o whenever valid_o is low.
`timescale 1ns/1ps

package ascon_perm_pkg;

  // Lane x0 is element [0], lane x4 is element [4].
  typedef logic [4:0][63:0] type_state;

  function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'h0, ~r, r};
    x3 = s[3];
    x4 = s[4];
    // Bit-sliced 5-bit S-box across all 64 columns.
    x0 ^= x4;
    x4 ^= x3;
    x2 ^= x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 ^= t1;
    x1 ^= t2;
    x2 ^= t3;
    x3 ^= t4;
    x4 ^= t0;
    x1 ^= x0;
    x0 ^= x4;
    x3 ^= x2;
    x2 = ~x2;
    x0 ^= {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    x1 ^= {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    x2 ^= {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    x3 ^= {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    x4 ^= {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return {x4, x3, x2, x1, x0};
  endfunction

endpackage

module ascon_perm_engine
  import ascon_perm_pkg::*;
#(
  parameter int UNROLL = 1  // legal: 1, 2, 3, 4, 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] nr_i,
  input  type_state  state_i,
  output logic       ready_o,
  output logic       valid_o,
  input  logic       out_ready_i,
  output type_state  state_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [3:0] MAX_ROUNDS = 4'd12;
  localparam logic [3:0] UNROLL_W   = 4'(UNROLL);

  fsm_t       fsm_q;
  type_state  state_q;
  logic [3:0] r_q;
  logic [3:0] rem_q;
  logic       ready_q;
  logic       valid_q;

  logic [3:0] nr_clamped;
  logic [3:0] step_k;
  type_state  chain [UNROLL+1];

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    nr_clamped = (nr_i > MAX_ROUNDS) ? MAX_ROUNDS : nr_i;
    step_k     = (rem_q < UNROLL_W) ? rem_q : UNROLL_W;
  end

  // Rounds past the remaining count pass the state through untouched.
  always_comb begin
    chain[0] = state_q;
    for (int i = 0; i < UNROLL; i++) begin
      chain[i+1] = (4'(i) < rem_q) ? ascon_round(chain[i], r_q + 4'(i)) : chain[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      // NOTE: the wide state register is reset because a reset must discard any result.
      state_q <= '0;
      r_q     <= 4'd0;
      rem_q   <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_q <= state_i;
            r_q     <= MAX_ROUNDS - nr_clamped;
            rem_q   <= nr_clamped;
            ready_q <= 1'b0;
            if (nr_clamped != 4'd0) begin
              fsm_q <= RUN;
            end else begin
              fsm_q   <= DONE;
              valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          state_q <= chain[UNROLL];
          r_q     <= r_q + step_k;
          rem_q   <= rem_q - step_k;
          if (rem_q == step_k) begin
            fsm_q   <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            fsm_q   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          fsm_q   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;

`ifdef ASCON_PERM_MASK_OUT_EN
  assign state_o = valid_q ? state_q : '0;
`else
  assign state_o = state_q;
`endif

endmodule
